// File: rtl/shift_seq_ctrl.sv
// Multi-cycle 32-bit shifter sequencer: latches one request, shifts STEP bits per
// cycle until the requested amount is applied, then pulses done with the result.
//
// state   | meaning
// S_IDLE  | waiting for a request
// S_SHIFT | iterating, busy=1
// S_DONE  | one cycle with done=1, result valid; may accept a new request
module shift_seq_ctrl #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  input  logic [1:0]  select,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  generate
    if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
      $error("shift_seq_ctrl: STEP must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [4:0] STEP_W = 5'(STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] work_q;
  logic [4:0]  rem_q;
  logic [1:0]  mode_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  logic        accept;
  logic [4:0]  step_k;
  logic [31:0] shifted;

  assign accept = start && (state_q != S_SHIFT);
  assign step_k = (rem_q > STEP_W) ? STEP_W : rem_q;

  // Arithmetic fill uses the live bit 31, which still equals the original sign.
  always_comb begin
    shifted = work_q;
    case (mode_q)
      2'b00:   shifted = work_q << step_k;
      2'b01:   shifted = work_q >> step_k;
      default: shifted = $signed(work_q) >>> step_k;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= 32'h0;
      rem_q    <= 5'd0;
      mode_q   <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'h0;
    end else if (accept) begin
      work_q <= a;
      rem_q  <= shamt;
      mode_q <= select;
      if (shamt == 5'd0) begin
        state_q  <= S_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= a;
      end else begin
        state_q <= S_SHIFT;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        S_SHIFT: begin
          work_q <= shifted;
          rem_q  <= rem_q - step_k;
          if (rem_q <= STEP_W) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= shifted;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (STEP=4): latency, busy length, result,
// ignored start while busy, back-to-back accept and asynchronous abort.
module tb_shift_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [4:0]  shamt;
  logic [1:0]  select;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq_ctrl #(.STEP(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .shamt  (shamt),
    .select (select),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after an edge; leaves us 1 unit after the accept edge.
  task automatic drive(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] mv);
    start  = 1'b1;
    a      = av;
    shamt  = sv;
    select = mv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts edges from the accept edge (accept edge = 1) until done is seen.
  task automatic wait_done(input int lat0, output int lat, output int nb);
    lat = lat0;
    nb  = 0;
    while (!done && lat < 60) begin
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, nb, extra;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 32'h0; shamt = 5'd0; select = 2'b00;
    #1;
    chk("rst_busy",   {31'h0, busy}, 32'h0);
    chk("rst_done",   {31'h0, done}, 32'h0);
    chk("rst_result", result,        32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // left 1 by 4
    drive(32'h0000_0001, 5'd4, 2'b00);
    wait_done(1, lat, nb);
    chk("sll4_lat",  lat, 2);
    chk("sll4_busy", nb, 1);
    chk("sll4_res",  result, 32'h0000_0010);
    @(posedge clk); #1;
    chk("sll4_done_clr", {31'h0, done}, 32'h0);

    // arithmetic right by 31
    drive(32'h8000_0000, 5'd31, 2'b10);
    wait_done(1, lat, nb);
    chk("sra31_lat",  lat, 9);
    chk("sra31_busy", nb, 8);
    chk("sra31_res",  result, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // logical right by 31
    drive(32'h8000_0000, 5'd31, 2'b01);
    wait_done(1, lat, nb);
    chk("srl31_lat", lat, 9);
    chk("srl31_res", result, 32'h0000_0001);
    @(posedge clk); #1;

    // zero shift
    drive(32'hDEAD_BEEF, 5'd0, 2'b01);
    chk("sh0_busy", {31'h0, busy}, 32'h0);
    wait_done(1, lat, nb);
    chk("sh0_lat", lat, 1);
    chk("sh0_res", result, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // start while busy is ignored
    drive(32'h0000_0003, 5'd9, 2'b00);
    @(posedge clk); #1;
    start = 1'b1; a = 32'hFFFF_FFFF; shamt = 5'd1; select = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3, lat, nb);
    chk("ign_lat", lat, 4);
    chk("ign_res", result, 32'h0000_0600);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("ign_no_second", extra, 0);
    chk("ign_res_hold", result, 32'h0000_0600);

    // back-to-back accept in the DONE cycle
    drive(32'h0000_00FF, 5'd8, 2'b00);
    wait_done(1, lat, nb);
    chk("b2b_first_lat", lat, 3);
    chk("b2b_first_res", result, 32'h0000_FF00);
    drive(32'hF000_0000, 5'd5, 2'b11);
    chk("b2b_busy",     {31'h0, busy}, 32'h1);
    chk("b2b_done_low", {31'h0, done}, 32'h0);
    chk("b2b_res_hold", result, 32'h0000_FF00);
    wait_done(1, lat, nb);
    chk("b2b_lat", lat, 3);
    chk("b2b_res", result, 32'hFF80_0000);
    @(posedge clk); #1;

    // asynchronous abort mid-shift
    drive(32'h0000_0001, 5'd20, 2'b00);
    @(posedge clk); #1;
    chk("abort_pre_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   {31'h0, busy}, 32'h0);
    chk("abort_done",   {31'h0, done}, 32'h0);
    chk("abort_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("abort_no_done", extra, 0);
    drive(32'h0000_0050, 5'd3, 2'b01);
    wait_done(1, lat, nb);
    chk("post_lat",  lat, 2);
    chk("post_busy", nb, 1);
    chk("post_res",  result, 32'h0000_000A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
